// File: rtl/error_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : error_monitor_if
// Description : Signal bundle between the error monitor and its environment.
//               The master side (sensor detector + supervisor) drives the raw
//               error flag, the acknowledge and the counter clear; the slave
//               side (error_monitor) returns alarm, strobe, count and state.
// Signals     : error       - raw sensor error flag
//               ack         - supervisor alarm acknowledge (level)
//               clr_count   - synchronous clear of err_count
//               alarm       - latched qualified alarm
//               alarm_pulse - one-cycle strobe on alarm entry
//               err_count   - saturating qualified-event count
//               state_o     - monitor FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
interface error_monitor_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 error;
    logic                 ack;
    logic                 clr_count;
    logic                 alarm;
    logic                 alarm_pulse;
    logic [CNT_WIDTH-1:0] err_count;
    logic [1:0]           state_o;

    modport master (
        output error, ack, clr_count,
        input  alarm, alarm_pulse, err_count, state_o
    );

    modport slave (
        input  error, ack, clr_count,
        output alarm, alarm_pulse, err_count, state_o
    );
endinterface
`default_nettype wire

// File: rtl/error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : error_monitor
// Description : Qualifies a raw sensor error flag by persistence, raises a
//               latched alarm until acknowledged, and keeps a saturating count
//               of qualified alarm events.
// Ports       : clk - system clock, rising edge
//               rst - synchronous active-high reset
//               bus - error_monitor_if slave modport
//                     (error, ack, clr_count in; alarm, alarm_pulse,
//                      err_count, state_o out)
// Parameters  : QUAL_CYCLES - consecutive high samples needed (1..255)
//               CNT_WIDTH   - width of err_count
// Revision    : 1.0 - initial release
// ============================================================================
module error_monitor #(
    parameter int QUAL_CYCLES = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    error_monitor_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ALARM   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [7:0]           c_QMAX    = 8'(QUAL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_qcnt;
    logic [7:0]           w_qcnt_nxt;
    logic                 r_alarm;
    logic                 r_alarm_pulse;
    logic [CNT_WIDTH-1:0] r_err_count;
    logic                 w_enter_alarm;

    // Next-state and qualify-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        unique case (r_state)
            IDLE: begin
                w_qcnt_nxt = 8'd0;
                if (bus.error) begin
                    if (QUAL_CYCLES == 1) begin
                        w_state_nxt = ALARM;
                    end else begin
                        w_state_nxt = QUALIFY;
                        w_qcnt_nxt  = 8'd1;
                    end
                end
            end
            QUALIFY: begin
                if (!bus.error) begin
                    // Glitch shorter than the qualify window: drop it silently.
                    w_state_nxt = IDLE;
                    w_qcnt_nxt  = 8'd0;
                end else if (r_qcnt >= c_QMAX) begin
                    w_state_nxt = ALARM;
                    w_qcnt_nxt  = 8'd0;
                end else begin
                    w_qcnt_nxt = r_qcnt + 8'd1;
                end
            end
            ALARM: begin
                w_qcnt_nxt = 8'd0;
                if (bus.ack) begin
                    // A fault still present on ack parks in HOLD so the same
                    // long fault cannot re-qualify into a second alarm.
                    w_state_nxt = bus.error ? HOLD : IDLE;
                end
            end
            HOLD: begin
                w_qcnt_nxt = 8'd0;
                if (!bus.error) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_qcnt_nxt  = 8'd0;
            end
        endcase
    end

    assign w_enter_alarm = (w_state_nxt == ALARM) && (r_state != ALARM);

    // State, qualify counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_qcnt        <= 8'd0;
            r_alarm       <= 1'b0;
            r_alarm_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_qcnt        <= w_qcnt_nxt;
            r_alarm       <= (w_state_nxt == ALARM);
            r_alarm_pulse <= w_enter_alarm;
        end
    end

    // Saturating event counter; a clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (bus.clr_count) begin
            r_err_count <= '0;
        end else if (w_enter_alarm && (r_err_count != c_CNT_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign bus.alarm       = r_alarm;
    assign bus.alarm_pulse = r_alarm_pulse;
    assign bus.err_count   = r_err_count;
    assign bus.state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_error_monitor
// Description : Self-checking bench for error_monitor. Three instances cover
//               QUAL_CYCLES=4/CNT_WIDTH=8, QUAL_CYCLES=4/CNT_WIDTH=2 and
//               QUAL_CYCLES=1/CNT_WIDTH=8. Expected results are queued when
//               each input cycle is driven and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_error_monitor;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_QUAL = 2'd1;
    localparam logic [1:0] c_ALRM = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #5 clk = ~clk;

    error_monitor_if #(.CNT_WIDTH(8)) if_a ();
    error_monitor_if #(.CNT_WIDTH(2)) if_b ();
    error_monitor_if #(.CNT_WIDTH(8)) if_c ();

    error_monitor #(.QUAL_CYCLES(4), .CNT_WIDTH(8)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    error_monitor #(.QUAL_CYCLES(4), .CNT_WIDTH(2)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
    error_monitor #(.QUAL_CYCLES(1), .CNT_WIDTH(8)) dut_c (.clk(clk), .rst(rst_c), .bus(if_c));

    typedef struct {
        int         sel;
        logic       rst;
        logic       err;
        logic       ack;
        logic       clr;
        logic [1:0] st;
        logic       al;
        logic       pu;
        logic [7:0] cnt;
    } vec_t;

    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one input cycle, queue its expectation, then compare after the edge.
    task automatic run(input vec_t v);
        vec_t       e;
        logic [1:0] st;
        logic       al, pu;
        logic [7:0] cnt;
        @(negedge clk);
        case (v.sel)
            0: begin rst_a = v.rst; if_a.error = v.err; if_a.ack = v.ack; if_a.clr_count = v.clr; end
            1: begin rst_b = v.rst; if_b.error = v.err; if_b.ack = v.ack; if_b.clr_count = v.clr; end
            default: begin rst_c = v.rst; if_c.error = v.err; if_c.ack = v.ack; if_c.clr_count = v.clr; end
        endcase
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
            return;
        end
        e = exp_q.pop_front();
        case (e.sel)
            0: begin st = if_a.state_o; al = if_a.alarm; pu = if_a.alarm_pulse; cnt = if_a.err_count; end
            1: begin st = if_b.state_o; al = if_b.alarm; pu = if_b.alarm_pulse; cnt = {6'd0, if_b.err_count}; end
            default: begin st = if_c.state_o; al = if_c.alarm; pu = if_c.alarm_pulse; cnt = if_c.err_count; end
        endcase
        chk($sformatf("state[dut%0d]", e.sel), {6'd0, st}, {6'd0, e.st});
        chk($sformatf("alarm[dut%0d]", e.sel), {7'd0, al}, {7'd0, e.al});
        chk($sformatf("alarm_pulse[dut%0d]", e.sel), {7'd0, pu}, {7'd0, e.pu});
        chk($sformatf("err_count[dut%0d]", e.sel), cnt, e.cnt);
    endtask

    task automatic step(input int sel, input logic r, input logic er, input logic ak, input logic cl,
                        input logic [1:0] st, input logic al, input logic pu, input logic [7:0] cnt);
        vec_t v;
        v.sel = sel; v.rst = r; v.err = er; v.ack = ak; v.clr = cl;
        v.st = st; v.al = al; v.pu = pu; v.cnt = cnt;
        run(v);
    endtask

    vec_t tbl[16];

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.error = 1'b0; if_a.ack = 1'b0; if_a.clr_count = 1'b0;
        if_b.error = 1'b0; if_b.ack = 1'b0; if_b.clr_count = 1'b0;
        if_c.error = 1'b0; if_c.ack = 1'b0; if_c.clr_count = 1'b0;

        // sel rst err ack clr  state  alarm pulse count
        // Glitch of 3 cycles on QUAL_CYCLES=4 is rejected.
        tbl[0]  = '{0, 1, 0, 0, 0, c_IDLE, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0, c_QUAL, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, c_QUAL, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0, c_QUAL, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, c_IDLE, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 0, c_IDLE, 0, 0, 0};
        // QUAL_CYCLES=1: single-cycle pulse alarms immediately.
        tbl[6]  = '{2, 1, 0, 0, 0, c_IDLE, 0, 0, 0};
        tbl[7]  = '{2, 0, 1, 0, 0, c_ALRM, 1, 1, 1};
        tbl[8]  = '{2, 0, 0, 0, 0, c_ALRM, 1, 0, 1};
        tbl[9]  = '{2, 0, 0, 1, 0, c_IDLE, 0, 0, 1};
        // Ack held high in advance does not suppress a new alarm.
        tbl[10] = '{2, 0, 1, 1, 0, c_ALRM, 1, 1, 2};
        tbl[11] = '{2, 0, 1, 1, 0, c_HOLD, 0, 0, 2};
        tbl[12] = '{2, 0, 1, 1, 0, c_HOLD, 0, 0, 2};
        tbl[13] = '{2, 0, 0, 1, 0, c_IDLE, 0, 0, 2};
        // clr_count alone in IDLE.
        tbl[14] = '{2, 0, 0, 0, 1, c_IDLE, 0, 0, 0};
        tbl[15] = '{2, 0, 0, 0, 0, c_IDLE, 0, 0, 0};

        repeat (2) @(posedge clk);
        for (int i = 0; i < 16; i++) run(tbl[i]);

        // Qualified alarm, latency and hold with ack=0.
        step(0, 1, 0, 0, 0, c_IDLE, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, c_QUAL, 0, 0, 0);
        step(0, 0, 1, 0, 0, c_ALRM, 1, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 0, (i % 2 == 0), 0, 0, c_ALRM, 1, 0, 1);

        // Ack with fault still present -> HOLD; long fault yields one alarm.
        step(0, 0, 1, 1, 0, c_HOLD, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, (i == 4), 0, c_HOLD, 0, 0, 1);
        step(0, 0, 0, 0, 0, c_IDLE, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, c_QUAL, 0, 0, 1);
        step(0, 0, 1, 0, 0, c_ALRM, 1, 1, 2);
        // clr_count in ALARM clears only the counter.
        step(0, 0, 1, 0, 1, c_ALRM, 1, 0, 0);
        // Reset mid-alarm.
        step(0, 1, 1, 0, 0, c_IDLE, 0, 0, 0);

        // Reset mid-qualify, fault held: alarm exactly 4 edges after release.
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, c_QUAL, 0, 0, 0);
        step(0, 1, 1, 0, 0, c_IDLE, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, c_QUAL, 0, 0, 0);
        step(0, 0, 1, 0, 0, c_ALRM, 1, 1, 1);

        // CNT_WIDTH=2 saturation: 1,2,3,3,3.
        step(1, 1, 0, 0, 0, c_IDLE, 0, 0, 0);
        for (int n = 1; n <= 5; n++) begin
            logic [7:0] ec;
            ec = (n < 3) ? 8'(n) : 8'd3;
            for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, c_QUAL, 0, 0, ((n - 1) < 3) ? 8'(n - 1) : 8'd3);
            step(1, 0, 1, 0, 0, c_ALRM, 1, 1, ec);
            step(1, 0, 0, 1, 0, c_IDLE, 0, 0, ec);
        end
        // Clear coincident with the 6th alarm entry wins.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, c_QUAL, 0, 0, 3);
        step(1, 0, 1, 0, 1, c_ALRM, 1, 1, 0);
        step(1, 0, 0, 1, 0, c_IDLE, 0, 0, 0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/error_monitor.md
Name: error_monitor

Overview:
- Downstream consumer of the combinational sensor-error detector's 1-bit `error` output.
- Qualifies `error` by requiring persistence over several cycles, rejecting glitches shorter than that.
- Raises a latched `alarm` that stays high until the supervisor acknowledges it.
- Keeps a saturating count of qualified error events for status readout.

Parameters:
- QUAL_CYCLES, 4, consecutive sampled-high cycles of `error` required to raise `alarm`; legal range 1..255.
- CNT_WIDTH, 8, width of the qualified-event counter `err_count`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- error  input  1  raw error flag from the sensor-error detector; sampled every rising edge.
- ack  input  1  alarm acknowledge from supervisor; level, sampled every edge.
- clr_count  input  1  synchronous clear of `err_count`.
- alarm  output  1  latched qualified alarm; registered.
- alarm_pulse  output  1  one-cycle strobe in the first cycle `alarm` is high; registered.
- err_count  output  CNT_WIDTH  number of qualified alarms, saturating; registered.
- state_o  output  2  current FSM state encoding: IDLE=0, QUALIFY=1, ALARM=2, HOLD=3.

Behaviour:
- Reset is the only asynchronous-free, single clock domain.
- rst=1 at any edge, including mid-qualify or mid-alarm, forces:
  - state=IDLE, qualify counter qcnt=0
  - alarm=0, alarm_pulse=0, err_count=0
- rst overrides all other inputs.
- qcnt is an internal 8-bit counter, clamped so it never exceeds QUAL_CYCLES-1.
- IDLE:
  - error=0: stay; qcnt=0.
  - error=1 and QUAL_CYCLES==1: go to ALARM.
  - error=1 and QUAL_CYCLES>1: go to QUALIFY; qcnt=1.
- QUALIFY:
  - error=0: go to IDLE; qcnt=0. The partial run is discarded and nothing is counted.
  - error=1 and qcnt==QUAL_CYCLES-1: go to ALARM.
  - Otherwise: qcnt+=1.
- ALARM (alarm=1):
  - ack=0: stay, regardless of error.
  - ack=1 and error=0: go to IDLE.
  - ack=1 and error=1: go to HOLD.
- HOLD (alarm=0):
  - Waits for the persisting fault to clear, so one long fault raises exactly one alarm.
  - error=0: go to IDLE. error=1: stay.
  - ack is ignored in HOLD.
- alarm is 1 exactly while state==ALARM, registered with the state.
- Latency: with error sampled high on edges k..k+QUAL_CYCLES-1, alarm goes high just after edge k+QUAL_CYCLES-1.
- ack is ignored in IDLE and QUALIFY; an ack held high in advance does not suppress a new alarm.
- alarm_pulse=1 only in the cycle following the transition into ALARM; 0 otherwise.
- err_count increments by 1 on each transition into ALARM and saturates at 2^CNT_WIDTH-1 (no wrap).
- clr_count=1 sets err_count=0 and has priority over a simultaneous increment; that event is lost.
- clr_count does not affect the FSM or alarm.
- Re-arming: after ALARM→IDLE, a new run of error requires the full QUAL_CYCLES again.

Test Plan:
1. Reset, QUAL_CYCLES=4: error=1 for 3 cycles then 0 → alarm stays 0, state returns to IDLE, err_count=0.
2. Reset; error=1 held 4 cycles → alarm=1 and alarm_pulse=1 right after the 4th edge; alarm_pulse=0 the next cycle; err_count=1; alarm stays 1 with ack=0 for 20 cycles.
3. In ALARM with error still 1, pulse ack=1 for one cycle → state HOLD, alarm=0; hold error=1 for 10 more cycles → no new alarm, err_count stays 1; drop error → IDLE; then error=1 for 4 cycles → second alarm, err_count=2.
4. CNT_WIDTH=2: produce 5 qualified alarms → err_count reads 1,2,3,3,3. Then assert clr_count in the same cycle as the 6th ALARM entry → err_count=0, alarm=1.
5. Mid-QUALIFY (qcnt=2), assert rst one cycle → all outputs 0, state IDLE; error kept at 1 → alarm asserts exactly 4 cycles after rst deasserts.
6. QUAL_CYCLES=1: single-cycle error pulse → alarm=1 after that edge, alarm_pulse=1 for one cycle; ack=1 with error=0 → IDLE next edge.
